countdown_trigger_sequencer: RTL and testbench
==============================================

// Module: countdown_trigger_sequencer
// PURPOSE
//  Downstream consumer of the countdown/timestamp interface. Drives cd_en, waits for cd_rdy,
//  fires a one-cycle op_trig, and logs the 48-bit timestamp of every firing into a FIFO.
//  The host reads the FIFO as 16-bit words. Repeats the load/count/fire cycle repeat_n times
//  per start, giving periodic, timestamped operation pulses in the fast clk domain.
// PARAMETERS
//  DEPTH        16  timestamp FIFO entries (power of 2, >=2); AW = clog2(DEPTH)
//  LOAD_CYCLES   2  cycles cd_en is held low to reload the down-counter (>=1)
//  RDY_MASK      2  cycles after entering COUNT during which cd_rdy is ignored (>=1)
// PORTS
//  clk       in   1    fast clock; all logic on posedge
//  rst_n     in   1    asynchronous, active-low reset
//  start     in   1    begin a sequence; sampled only in IDLE
//  abort     in   1    terminate the sequence; returns to IDLE
//  repeat_n  in   16   number of firings per start; latched on start; 0 treated as 1
//  cd_rdy    in   1    down-counter reached zero
//  timestamp in   48   free-running time count
//  cd_en     out  1    0 = counter loads, 1 = counter counts down
//  op_trig   out  1    one-cycle operation trigger
//  busy      out  1    high in every state except IDLE
//  done      out  1    one-cycle pulse when the final firing completes
//  ts_rd     in   1    advance the FIFO read word
//  ts_word   out  16   current word of the FIFO head entry
//  ts_count  out  AW+1 entries held in the FIFO
//  ts_empty  out  1    ts_count == 0
//  ts_full   out  1    ts_count == DEPTH
//  ts_ovf    out  1    sticky: a firing was dropped because the FIFO was full
//  ovf_clr   in   1    clears ts_ovf
// BEHAVIOUR
//  Reset: state IDLE; cd_en=0, op_trig=0, done=0, busy=0; FIFO empty; word select=0;
//   ts_ovf=0; ts_word=0.
//  All outputs are registered or decoded from state (Moore). No combinational input->output paths.
//  FSM states and transitions:
//   IDLE:  cd_en=0. On start: latch rem = (repeat_n==0 ? 1 : repeat_n), then go to LOAD.
//   LOAD:  cd_en=0 for exactly LOAD_CYCLES cycles, then go to COUNT.
//   COUNT: cd_en=1. The first RDY_MASK cycles ignore cd_rdy. After that, cd_rdy=1 moves to FIRE
//          on the next edge.
//   FIRE:  one cycle; op_trig=1, cd_en=0. Push the timestamp sampled in this cycle; rem <= rem-1.
//          If rem==1, go to IDLE and pulse done in the next cycle. Otherwise go to LOAD.
//   Latency: the cd_rdy sample that qualifies the fire is followed by op_trig on the next cycle.
//  abort:
//   In any non-IDLE state, go to IDLE on the next edge, with no done.
//   In FIRE, the current trigger and push still complete.
//   abort beats start when both are high in IDLE.
//  start while busy is ignored. repeat_n changes after the start sample have no effect.
//  FIFO:
//   Entries are 48 bits. ts_word shows the head entry's word [15:0], then [31:16], then [47:32],
//    selected by a 2-bit sel.
//   ts_rd when not empty: if sel<2, sel++; if sel==2, pop the entry and set sel=0.
//    ts_rd when empty is ignored. ts_word=0 when empty.
//   Push when not full, or when full and a pop happens in the same cycle.
//    Otherwise the entry is dropped and ts_ovf is set.
//   ts_count is correct for simultaneous push and pop (unchanged). Pointers wrap modulo DEPTH.
//   ovf_clr clears ts_ovf. If a set and a clear occur in the same cycle, set wins.
//  Reset mid-operation: everything returns to reset values immediately; FIFO contents are lost.
// TESTING
//  1. Reset, then start with repeat_n=3 and cd_rdy pulsed 5 cycles into each COUNT
//     -> 3 op_trig, 3 entries, done once, busy drops with done.
//  2. timestamp=48'h0123_4567_89AB at the FIRE cycle, then 3x ts_rd
//     -> ts_word 16'h89AB, 16'h4567, 16'h0123; then ts_empty=1.
//  3. repeat_n=0 -> exactly 1 firing; cd_rdy held high throughout -> no fire inside the
//     RDY_MASK window after each LOAD.
//  4. DEPTH=16, 18 firings with no reads -> ts_count=16, ts_ovf=1; ovf_clr -> ts_ovf=0;
//     entries 1-16 are retained.
//  5. abort during COUNT -> IDLE next cycle, cd_en=0, no op_trig, no done.
//     abort during FIRE -> the entry is pushed, no done.
//  6. rst_n low mid-COUNT with 2 entries queued -> all outputs at reset values,
//     ts_count=0, asynchronously.

Source files
------------

// File: rtl/countdown_trigger_sequencer_if.sv
// Countdown/timestamp handshake plus host-side timestamp FIFO read port.
// master = sequencer side, slave = counter/host side.
interface countdown_trigger_sequencer_if #(
    parameter int DEPTH = 16
);
    logic                      cd_en;
    logic                      cd_rdy;
    logic [47:0]               timestamp;
    logic                      ts_rd;
    logic [15:0]               ts_word;
    logic [$clog2(DEPTH):0]    ts_count;
    logic                      ts_empty;
    logic                      ts_full;
    logic                      ts_ovf;
    logic                      ovf_clr;

    modport master (
        output cd_en, ts_word, ts_count, ts_empty, ts_full, ts_ovf,
        input  cd_rdy, timestamp, ts_rd, ovf_clr
    );

    modport slave (
        input  cd_en, ts_word, ts_count, ts_empty, ts_full, ts_ovf,
        output cd_rdy, timestamp, ts_rd, ovf_clr
    );
endinterface

// File: rtl/countdown_trigger_sequencer.sv
// Load/count/fire sequencer driving a down-counter, with a timestamp FIFO
// of every firing that the host reads back as 16-bit words.
module countdown_trigger_sequencer #(
    parameter int DEPTH       = 16,
    parameter int LOAD_CYCLES = 2,
    parameter int RDY_MASK    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] repeat_n,
    output logic        op_trig,
    output logic        busy,
    output logic        done,
    countdown_trigger_sequencer_if.master cd
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (LOAD_CYCLES > RDY_MASK) ? LOAD_CYCLES : RDY_MASK;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, FIRE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   rem;
    logic          cd_en_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            cd_en_q <= 1'b0;
            op_trig <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            op_trig <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        rem   <= (repeat_n == 16'd0) ? 16'd1 : repeat_n;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CW'(LOAD_CYCLES - 1)) begin
                        state   <= COUNT;
                        cd_en_q <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COUNT: begin
                    // cd_rdy may still reflect the previous count right after a reload
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cd_en_q <= 1'b0;
                    end else if (cnt < CW'(RDY_MASK)) begin
                        cnt <= cnt + 1'b1;
                    end else if (cd.cd_rdy) begin
                        state   <= FIRE;
                        cd_en_q <= 1'b0;
                        op_trig <= 1'b1;
                    end
                end
                FIRE: begin
                    rem <= rem - 1'b1;
                    cnt <= '0;
                    if (abort || rem == 16'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= !abort;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cd.cd_en = cd_en_q;

    logic [47:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    sel;
    logic          ovf_q;
    logic          empty;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign push_req = (state == FIRE);
    assign pop      = cd.ts_rd && !empty && (sel == 2'd2);
    // A full FIFO still accepts the firing if the head leaves in the same cycle
    assign push_ok  = push_req && (!full || pop);

    // NOTE: the storage array has no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= cd.timestamp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sel    <= 2'd0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (cd.ts_rd && !empty) sel <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            if (push_req && !push_ok) ovf_q <= 1'b1;
            else if (cd.ovf_clr)      ovf_q <= 1'b0;
        end
    end

    logic [47:0] head;
    logic [15:0] word;
    assign head = mem[rd_ptr];

    // NOTE: default assignment first so no path through this block infers a latch.
    always_comb begin
        word = '0;
        if (!empty) begin
            case (sel)
                2'd0:    word = head[15:0];
                2'd1:    word = head[31:16];
                default: word = head[47:32];
            endcase
        end
    end

    assign cd.ts_word  = word;
    assign cd.ts_count = count;
    assign cd.ts_empty = empty;
    assign cd.ts_full  = full;
    assign cd.ts_ovf   = ovf_q;
endmodule

// File: tb/tb_countdown_trigger_sequencer.sv
// Scoreboard bench: stimulus queues expected trigger/done cycles and read words,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_countdown_trigger_sequencer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] repeat_n = 16'd0;
    logic        op_trig;
    logic        busy;
    logic        done;

    countdown_trigger_sequencer_if #(.DEPTH(DEPTH)) cd_if ();

    countdown_trigger_sequencer #(
        .DEPTH(DEPTH), .LOAD_CYCLES(2), .RDY_MASK(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .repeat_n(repeat_n), .op_trig(op_trig), .busy(busy), .done(done),
        .cd(cd_if.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          trig_q[$];
    int          done_q[$];
    logic [15:0] word_q[$];
    int          exp_count_cyc;
    int          mon_exp;
    logic [15:0] mon_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations
    always @(negedge clk) begin
        if (rst_n) begin
            if (op_trig) begin
                if (trig_q.size() == 0) check("op_trig_unexpected", op_trig, 1'b0);
                else begin
                    mon_exp = trig_q.pop_front();
                    check("op_trig_cycle", cyc, mon_exp);
                end
            end
            if (done) begin
                if (done_q.size() == 0) check("done_unexpected", done, 1'b0);
                else begin
                    mon_exp = done_q.pop_front();
                    check("done_cycle", cyc, mon_exp);
                    check("busy_with_done", busy, 1'b0);
                end
            end
            if (cd_if.ts_rd) begin
                if (word_q.size() == 0) check("ts_rd_unexpected", cd_if.ts_rd, 1'b0);
                else begin
                    mon_word = word_q.pop_front();
                    check("ts_word", cd_if.ts_word, mon_word);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        repeat_n = n;
        exp_count_cyc = cyc + 3;
        tick();
        start = 1'b0;
        repeat_n = 16'hFFFF;
    endtask

    task automatic wait_count_entry(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            seen = cd_if.cd_en;
        end
        check("cd_en_rise_seen", seen, 1'b1);
        if (seen) check("count_entry_cycle", cyc, exp_count_cyc);
    endtask

    // Pulse cd_rdy in the 5th COUNT cycle; returns during the FIRE cycle
    task automatic fire_once(input logic [47:0] ts, input bit last);
        bit seen;
        wait_count_entry(seen);
        if (seen) begin
            repeat (4) tick();
            cd_if.cd_rdy = 1'b1;
            cd_if.timestamp = ts;
            trig_q.push_back(cyc + 1);
            if (last) done_q.push_back(cyc + 2);
            exp_count_cyc = cyc + 4;
            tick();
            cd_if.cd_rdy = 1'b0;
        end
    endtask

    task automatic read_word(input logic [15:0] w);
        cd_if.ts_rd = 1'b1;
        word_q.push_back(w);
        tick();
        cd_if.ts_rd = 1'b0;
    endtask

    task automatic read_entry(input logic [47:0] e);
        read_word(e[15:0]);
        read_word(e[31:16]);
        read_word(e[47:32]);
    endtask

    initial begin
        int s;
        bit seen;
        cd_if.cd_rdy = 1'b0;
        cd_if.timestamp = '0;
        cd_if.ts_rd = 1'b0;
        cd_if.ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_cd_en", cd_if.cd_en, 1'b0);
        check("rst_op_trig", op_trig, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ts_count", cd_if.ts_count, 0);
        check("rst_ts_empty", cd_if.ts_empty, 1'b1);
        check("rst_ts_word", cd_if.ts_word, 16'h0);
        check("rst_ts_ovf", cd_if.ts_ovf, 1'b0);

        // Three firings per start
        tick();
        do_start(16'd3);
        check("busy_after_start", busy, 1'b1);
        fire_once(48'h0123_4567_89AB, 1'b0);
        fire_once(48'h0000_1111_2222, 1'b0);
        fire_once(48'h0000_3333_4444, 1'b1);
        tick(); tick();
        check("t1_busy_idle", busy, 1'b0);
        check("t1_count", cd_if.ts_count, 3);

        // Word order of the head entry, then empty behaviour
        read_entry(48'h0123_4567_89AB);
        read_entry(48'h0000_1111_2222);
        read_entry(48'h0000_3333_4444);
        check("t2_empty", cd_if.ts_empty, 1'b1);
        check("t2_word_empty", cd_if.ts_word, 16'h0);
        read_word(16'h0);
        check("t2_count_after_empty_rd", cd_if.ts_count, 0);

        // repeat_n=0 fires once; cd_rdy held high must respect the mask window
        cd_if.timestamp = 48'h0000_0000_0003;
        cd_if.cd_rdy = 1'b1;
        s = cyc;
        do_start(16'd0);
        trig_q.push_back(s + 6);
        done_q.push_back(s + 7);
        repeat (12) tick();
        check("t3a_count", cd_if.ts_count, 1);
        s = cyc;
        do_start(16'd2);
        trig_q.push_back(s + 6);
        trig_q.push_back(s + 12);
        done_q.push_back(s + 13);
        repeat (16) tick();
        cd_if.cd_rdy = 1'b0;
        check("t3b_count", cd_if.ts_count, 3);
        check("t3b_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) read_entry(48'h0000_0000_0003);

        // Overflow: 18 firings into 16 entries
        do_start(16'd18);
        for (int i = 1; i <= 18; i++) fire_once(48'h100 + 48'(i), i == 18);
        tick(); tick();
        check("t4_count", cd_if.ts_count, 16);
        check("t4_full", cd_if.ts_full, 1'b1);
        check("t4_ovf", cd_if.ts_ovf, 1'b1);
        cd_if.ovf_clr = 1'b1;
        tick();
        cd_if.ovf_clr = 1'b0;
        check("t4_ovf_clr", cd_if.ts_ovf, 1'b0);
        for (int i = 1; i <= 16; i++) read_entry(48'h100 + 48'(i));
        check("t4_empty", cd_if.ts_empty, 1'b1);

        // Abort during COUNT
        do_start(16'd1);
        wait_count_entry(seen);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5a_cd_en", cd_if.cd_en, 1'b0);
        check("t5a_busy", busy, 1'b0);
        cd_if.cd_rdy = 1'b1;
        repeat (6) tick();
        cd_if.cd_rdy = 1'b0;

        // Abort during FIRE: entry still pushed, no done
        do_start(16'd2);
        fire_once(48'hABCD_0000_5555, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5b_busy", busy, 1'b0);
        check("t5b_count", cd_if.ts_count, 1);
        repeat (10) tick();
        read_entry(48'hABCD_0000_5555);

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", busy, 1'b0);

        // Asynchronous reset mid-COUNT with two entries queued
        do_start(16'd3);
        fire_once(48'h0000_0000_00A1, 1'b0);
        fire_once(48'h0000_0000_00A2, 1'b0);
        wait_count_entry(seen);
        tick();
        check("t6_count_before", cd_if.ts_count, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_cd_en", cd_if.cd_en, 1'b0);
        check("t6_op_trig", op_trig, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        check("t6_ts_count", cd_if.ts_count, 0);
        check("t6_ts_empty", cd_if.ts_empty, 1'b1);
        check("t6_ts_word", cd_if.ts_word, 16'h0);
        check("t6_ts_ovf", cd_if.ts_ovf, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick();

        check("trig_q_drained", trig_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        check("word_q_drained", word_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
